// File: rtl/led_pixel_rx_if.sv
// Decoded pixel stream from the one-wire LED receiver: pixel words plus frame and error strobes.
interface led_pixel_rx_if #(
  parameter int NUM_BITS = 24
);
  logic [NUM_BITS-1:0] pixel_data;
  logic                pixel_valid;
  logic [7:0]          pixel_index;
  logic                frame_done;
  logic                bit_error;

  modport master (
    output pixel_data,
    output pixel_valid,
    output pixel_index,
    output frame_done,
    output bit_error
  );

  modport slave (
    input pixel_data,
    input pixel_valid,
    input pixel_index,
    input frame_done,
    input bit_error
  );
endinterface

// File: rtl/led_pixel_rx.sv
// One-wire LED pixel receiver: measures high-pulse widths, assembles MSB-first pixel words,
// detects the latch gap that ends a frame, and forwards later pixels downstream on dout.
module led_pixel_rx #(
  parameter int NUM_BITS        = 24,
  parameter int MIN_HIGH_CYCLES = 8,
  parameter int THRESH_CYCLES   = 60,
  parameter int MAX_HIGH_CYCLES = 150,
  parameter int LATCH_CYCLES    = 5000
) (
  input  logic clk_in,
  input  logic rst_in_n,
  input  logic din,
  output logic dout,
  led_pixel_rx_if.master pix
);
  // state  | meaning
  // RESYNC | after reset/error: wait for a full latch gap of low before decoding
  // IDLE   | frame boundary seen, waiting for the first rising edge
  // HIGH   | measuring a high pulse
  // LOW    | between bits, timing the low gap for a latch
  typedef enum logic [1:0] {RESYNC, IDLE, HIGH, LOW} state_t;

  localparam int HW = $clog2(MAX_HIGH_CYCLES + 2);
  localparam int LW = $clog2(LATCH_CYCLES + 1);
  localparam int BW = $clog2(NUM_BITS + 1);

  localparam logic [HW-1:0] MIN_H    = HW'(MIN_HIGH_CYCLES);
  localparam logic [HW-1:0] THRESH_H = HW'(THRESH_CYCLES);
  localparam logic [HW-1:0] MAX_H    = HW'(MAX_HIGH_CYCLES);
  localparam logic [HW-1:0] ONE_H    = HW'(1);
  localparam logic [LW-1:0] LATCH_L  = LW'(LATCH_CYCLES);
  localparam logic [BW-1:0] LAST_BIT = BW'(NUM_BITS - 1);

  logic [1:0]          rst_sync;
  logic                rst_n;
  logic                din_meta;
  logic                din_s;
  logic                din_d;
  logic                rise;
  logic                fall;
  logic                bit_val;
  state_t              state;
  logic [HW-1:0]       high_cnt;
  logic [LW-1:0]       low_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [NUM_BITS-2:0] word;
  logic [NUM_BITS-1:0] word_next;
  logic [7:0]          pix_cnt;
  logic                passthru;

  // Assert asynchronously, release on a clock edge.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) rst_sync <= 2'b00;
    else           rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  assign rise      = din_s & ~din_d;
  assign fall      = ~din_s & din_d;
  assign bit_val   = (high_cnt >= THRESH_H);
  // The word register holds only the bits already shifted; the bit being decoded completes it.
  assign word_next = {word, bit_val};

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      din_meta        <= 1'b0;
      din_s           <= 1'b0;
      din_d           <= 1'b0;
      dout            <= 1'b0;
      state           <= RESYNC;
      high_cnt        <= '0;
      low_cnt         <= '0;
      bit_cnt         <= '0;
      word            <= '0;
      pix_cnt         <= 8'd0;
      passthru        <= 1'b0;
      pix.pixel_data  <= '0;
      pix.pixel_valid <= 1'b0;
      pix.pixel_index <= 8'd0;
      pix.frame_done  <= 1'b0;
      pix.bit_error   <= 1'b0;
    end else begin
      din_meta        <= din;
      din_s           <= din_meta;
      din_d           <= din_s;
      dout            <= passthru & din_s;
      pix.pixel_valid <= 1'b0;
      pix.frame_done  <= 1'b0;
      pix.bit_error   <= 1'b0;

      case (state)
        RESYNC: begin
          if (din_s) begin
            low_cnt <= '0;
          end else if (low_cnt == LATCH_L) begin
            low_cnt <= '0;
            state   <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        IDLE: begin
          if (rise) begin
            high_cnt <= ONE_H;
            state    <= HIGH;
          end
        end

        HIGH: begin
          if ((high_cnt > MAX_H) || (fall && (high_cnt < MIN_H))) begin
            // The latch wait in RESYNC ends this frame, so frame bookkeeping restarts too.
            pix.bit_error <= 1'b1;
            word          <= '0;
            bit_cnt       <= '0;
            pix_cnt       <= 8'd0;
            passthru      <= 1'b0;
            low_cnt       <= '0;
            state         <= RESYNC;
          end else if (fall) begin
            low_cnt <= '0;
            state   <= LOW;
            if (bit_cnt == LAST_BIT) begin
              pix.pixel_data  <= word_next;
              pix.pixel_valid <= 1'b1;
              pix.pixel_index <= pix_cnt;
              bit_cnt         <= '0;
              word            <= '0;
              if (pix_cnt != 8'hFF) pix_cnt <= pix_cnt + 8'd1;
              // din_s is already low here, so dout can only start on a whole pulse.
              passthru        <= 1'b1;
            end else begin
              word    <= word_next[NUM_BITS-2:0];
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else begin
            // Overflow is caught above, so this stops at MAX_HIGH_CYCLES + 1.
            high_cnt <= high_cnt + 1'b1;
          end
        end

        LOW: begin
          if (rise) begin
            high_cnt <= ONE_H;
            state    <= HIGH;
          end else if (low_cnt == LATCH_L) begin
            pix.frame_done <= 1'b1;
            pix.bit_error  <= (bit_cnt != '0);
            bit_cnt        <= '0;
            word           <= '0;
            pix_cnt        <= 8'd0;
            passthru       <= 1'b0;
            state          <= IDLE;
          end else begin
            low_cnt <= low_cnt + 1'b1;
          end
        end

        default: state <= RESYNC;
      endcase
    end
  end
endmodule
